// File: rtl/demux32_1to4_buf_pkg.sv
// Shared constants for the 1-to-4 buffered demux.
// Slot indices, default width and the pointer step helper.
package demux32_1to4_buf_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] SLOT0 = 2'b00;
    localparam logic [1:0] SLOT1 = 2'b01;
    localparam logic [1:0] SLOT2 = 2'b10;
    localparam logic [1:0] SLOT3 = 2'b11;

    localparam int NUM_SLOTS = 4;

    // Round-robin step; the 2-bit add wraps 3 back to 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return p + 2'b01;
    endfunction

    // One-hot decode of a slot index.
    function automatic logic [3:0] slot_onehot(input logic [1:0] s);
        logic [3:0] oh;
        oh = 4'b0000;
        unique case (s)
            SLOT0: oh = 4'b0001;
            SLOT1: oh = 4'b0010;
            SLOT2: oh = 4'b0100;
            SLOT3: oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux32_1to4_buf_if.sv
// Producer/consumer bundle for the 1-to-4 buffered demux.
// master = producer and consumers side, slave = the demux.
interface demux32_1to4_buf_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_auto;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ack;
    logic [1:0]       rr_ptr;

    modport master (
        output in_valid,
        output in_data,
        output in_sel,
        output in_auto,
        output out_ack,
        input  in_ready,
        input  out_data0,
        input  out_data1,
        input  out_data2,
        input  out_data3,
        input  out_valid,
        input  rr_ptr
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sel,
        input  in_auto,
        input  out_ack,
        output in_ready,
        output out_data0,
        output out_data1,
        output out_data2,
        output out_data3,
        output out_valid,
        output rr_ptr
    );

endinterface

// File: rtl/demux32_1to4_buf_slot.sv
// One holding slot: data register plus valid flag.
// Clear beats load, load beats ack; ack on an empty slot is a no-op.
module demux_slot
    import demux32_1to4_buf_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             ack_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;

    // Next-state: a load refills even when acked the same cycle.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (ack_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/demux32_1to4_buf.sv
// Steers one producer stream into four one-entry slots.
// Destination is in_sel or a round-robin pointer in auto mode.
module demux32_1to4_buf
    import demux32_1to4_buf_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    demux32_1to4_buf_if.slave    bus
);

    logic             clr;
    logic [1:0]       dst;
    logic             ready;
    logic             xfer;
    logic [3:0]       load;
    logic [3:0]       slot_valid;
    logic [WIDTH-1:0] slot_data [NUM_SLOTS];
    logic [1:0]       rr_ptr_q;
    logic [1:0]       rr_ptr_d;

    // Destination pick and the combinational accept decision.
    always_comb begin
        clr   = reset | flush;
        dst   = bus.in_auto ? rr_ptr_q : bus.in_sel;
        ready = !clr && (!slot_valid[dst] || bus.out_ack[dst]);
        xfer  = bus.in_valid && ready;
    end

    // Route the accepted beat to exactly one slot.
    always_comb begin
        load = 4'b0000;
        if (xfer) begin
            load = slot_onehot(dst);
        end
    end

    // Pointer moves only on auto-mode transfers.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer && bus.in_auto) begin
            rr_ptr_d = ptr_inc(rr_ptr_q);
        end
    end

    // Pointer register, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (clr) begin
            rr_ptr_q <= SLOT0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        demux_slot #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_slot (
            .clk     (clk),
            .clr_i   (clr),
            .load_i  (load[i]),
            .ack_i   (bus.out_ack[i]),
            .data_i  (bus.in_data),
            .data_o  (slot_data[i]),
            .valid_o (slot_valid[i])
        );
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = slot_valid;
    assign bus.out_data0 = slot_data[0];
    assign bus.out_data1 = slot_data[1];
    assign bus.out_data2 = slot_data[2];
    assign bus.out_data3 = slot_data[3];
    assign bus.rr_ptr    = rr_ptr_q;

endmodule
